regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_seq_pkg.sv | 47 ++++
 rtl/rs_alu.sv | 36 +++
 rtl/regfile_sequencer.sv | 168 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
//   Shared definitions for the register-file sequencer: instruction field
//   positions, opcode values, FSM state encoding and a small opcode helper.
package regfile_seq_pkg;

  // Instruction field positions inside the 16-bit instruction word.
  // The imm field overlaps srcA/srcB and is only meaningful for LDI.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 9;
  localparam int SRCA_MSB = 8;
  localparam int SRCA_LSB = 6;
  localparam int SRCB_MSB = 5;
  localparam int SRCB_LSB = 3;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam int INSTR_W  = 16;
  localparam int FIELD_W  = 3;
  localparam int IMM_W    = 8;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Everything above NOT is undefined and must not write.
  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_NOT;
  endfunction

endpackage

// File: rtl/rs_alu.sv
// rs_alu
//   Purely combinational ALU for the register-file sequencer.
//   Ports:
//     opcode  in  4         instruction opcode
//     a, b    in  DATA_W    operands (already forced to 0 for source R0)
//     imm     in  8         LDI immediate
//     cr      out DATA_W+1  {carry, result}
//   Carry is the ADD carry-out, the SUB borrow (a < b), and 0 for all others.
module rs_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W:0]   cr
);

  always_comb begin
    cr = '0;
    case (opcode)
      OP_ADD:  cr = {1'b0, a} + {1'b0, b};
      OP_SUB:  cr = {(a < b), a - b};
      OP_AND:  cr = {1'b0, a & b};
      OP_OR:   cr = {1'b0, a | b};
      OP_XOR:  cr = {1'b0, a ^ b};
      OP_MOV:  cr = {1'b0, a};
      OP_LDI:  cr = {1'b0, DATA_W'(imm)};
      OP_NOT:  cr = {1'b0, ~a};
      default: cr = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Sequences one instruction at a time against an external register file
//   with registered read data.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     instr_valid/instr   instruction offer; instr_ready high only when IDLE
//     AA, BA              read addresses (driven only in RD, 0 otherwise)
//     Data_A, Data_B      registered read data, valid in CAP
//     DA, Data_in, WR     write port, active only in WB
//     done                one-cycle completion pulse (DONE state)
//     result/carry/zero/illegal  status of the last completed instruction
//   Paths: ALU ops IDLE-RD-CAP-WB-DONE, LDI IDLE-WB-DONE, NOP/illegal IDLE-DONE.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  AA,
  output logic [ADDR_W-1:0]  BA,
  output logic [ADDR_W-1:0]  DA,
  output logic [DATA_W-1:0]  Data_in,
  output logic               WR,
  input  logic [DATA_W-1:0]  Data_A,
  input  logic [DATA_W-1:0]  Data_B,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               carry,
  output logic               zero,
  output logic               illegal
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;

  logic                 accept;
  logic [INSTR_W-1:0]   cur_instr;
  logic [3:0]           opc;
  logic [FIELD_W-1:0]   dest, src_a, src_b;
  logic [IMM_W-1:0]     imm;
  logic [DATA_W-1:0]    op_a, op_b;
  logic [DATA_W:0]      alu_cr;

  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // LDI loads its result on the accepting edge, so in IDLE the ALU looks at
  // the incoming offer; afterwards it works from the latched copy.
  assign cur_instr = (state_q == ST_IDLE) ? instr : instr_q;
  assign opc       = cur_instr[OPC_MSB:OPC_LSB];
  assign dest      = cur_instr[DEST_MSB:DEST_LSB];
  assign src_a     = cur_instr[SRCA_MSB:SRCA_LSB];
  assign src_b     = cur_instr[SRCB_MSB:SRCB_LSB];
  assign imm       = cur_instr[IMM_MSB:IMM_LSB];

  // R0 reads as zero: the register file is not addressed for R0 and its
  // read data still holds whatever the previous read returned.
  assign op_a = (state_q == ST_CAP && src_a != '0) ? Data_A : '0;
  assign op_b = (state_q == ST_CAP && src_b != '0) ? Data_B : '0;

  rs_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (opc),
    .a      (op_a),
    .b      (op_b),
    .imm    (imm),
    .cr     (alu_cr)
  );

  // Next state and status register loads
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          instr_d = instr;
          if (opc == OP_NOP) begin
            state_d   = ST_DONE;
            illegal_d = 1'b0;
          end else if (op_illegal(opc)) begin
            state_d   = ST_DONE;
            illegal_d = 1'b1;
          end else if (opc == OP_LDI) begin
            state_d   = ST_WB;
            result_d  = alu_cr[DATA_W-1:0];
            carry_d   = alu_cr[DATA_W];
            zero_d    = (alu_cr[DATA_W-1:0] == '0);
            illegal_d = 1'b0;
          end else begin
            state_d   = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        state_d   = ST_WB;
        result_d  = alu_cr[DATA_W-1:0];
        carry_d   = alu_cr[DATA_W];
        zero_d    = (alu_cr[DATA_W-1:0] == '0);
        illegal_d = 1'b0;
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Register-file port drive. WR and done are gated by rst so a reset that
  // lands in WB or DONE suppresses the write and the completion pulse.
  always_comb begin
    AA      = '0;
    BA      = '0;
    DA      = '0;
    Data_in = '0;
    WR      = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_RD: begin
        AA = ADDR_W'(src_a);
        BA = ADDR_W'(src_b);
      end
      ST_WB: begin
        DA      = ADDR_W'(dest);
        Data_in = result_q;
        WR      = (dest != '0) && !rst;
      end
      ST_DONE: done = !rst;
      default: ;
    endcase
  end

  assign result  = result_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: an external 8x8 register file, a per-cycle
// compare process driven by an instruction-level model, and directed
// instruction sequences with literal expectations.
module tb_regfile_sequencer;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic [15:0]   instr = '0;
  logic          instr_ready;
  logic [AW-1:0] AA, BA, DA;
  logic [DW-1:0] Data_in;
  logic          WR;
  logic [DW-1:0] Data_A = '0;
  logic [DW-1:0] Data_B = '0;
  logic          done;
  logic [DW-1:0] result;
  logic          carry, zero, illegal;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .AA(AA), .BA(BA), .DA(DA), .Data_in(Data_in),
    .WR(WR), .Data_A(Data_A), .Data_B(Data_B), .done(done), .result(result),
    .carry(carry), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External register file: registered reads, and address 0 is never
  // driven by a read so the read data simply holds.
  logic [DW-1:0] rf [8] = '{default: '0};
  always @(posedge clk) begin
    if (WR) rf[DA] <= Data_in;
    if (AA != '0) Data_A <= rf[AA];
    if (BA != '0) Data_B <= rf[BA];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- instruction-level model ----------------
  int         mrf [8] = '{default: 0};
  bit         m_busy = 0, m_rd = 0, m_wb = 0, m_upd = 0, m_wr_en = 0;
  int         m_rd_cyc, m_wr_cyc, m_done_cyc;
  logic [2:0] m_dest, m_sa, m_sb;
  int         p_res;
  bit         p_c, p_z, p_ill;
  int         s_res = 0;
  bit         s_c = 0, s_z = 0, s_ill = 0;

  // Instruction accepted at edge t; cycle t is the one that edge starts.
  task automatic model_accept(input logic [15:0] ins, input int t);
    int a, b, r;
    logic [3:0] op;
    op     = ins[15:12];
    m_dest = ins[11:9];
    m_sa   = ins[8:6];
    m_sb   = ins[5:3];
    a = (m_sa == 0) ? 0 : mrf[m_sa];
    b = (m_sb == 0) ? 0 : mrf[m_sb];
    m_busy = 1; m_rd = 1; m_wb = 1; m_upd = 1; m_wr_en = (m_dest != 0);
    m_rd_cyc = t; m_wr_cyc = t + 2; m_done_cyc = t + 3;
    p_c = 0; p_ill = 0; r = 0;
    case (op)
      4'h0: begin m_rd = 0; m_wb = 0; m_upd = 0; m_done_cyc = t; end
      4'h1: begin r = a + b; p_c = (r > 255); end
      4'h2: begin r = a - b; p_c = (a < b); end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = a;
      4'h7: begin r = int'(ins[7:0]); m_rd = 0; m_wr_cyc = t; m_done_cyc = t + 1; end
      4'h8: r = ~a;
      default: begin m_rd = 0; m_wb = 0; m_upd = 0; m_done_cyc = t; p_ill = 1; end
    endcase
    p_res = r & 255;
    p_z   = (p_res == 0);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int k;
    bit e_rdy, e_wr, e_done;
    logic [2:0] e_aa, e_ba;
    k = cyc;
    if (k >= 1) begin
      e_rdy  = !rst && !m_busy;
      e_wr   = !rst && m_busy && m_wb && m_wr_en && (k == m_wr_cyc);
      e_done = !rst && m_busy && (k == m_done_cyc);
      chk("instr_ready", instr_ready, e_rdy);
      chk("WR", WR, e_wr);
      chk("done", done, e_done);
      if (!rst) begin
        e_aa = (m_busy && m_rd && k == m_rd_cyc) ? m_sa : 3'd0;
        e_ba = (m_busy && m_rd && k == m_rd_cyc) ? m_sb : 3'd0;
        chk("AA", AA, e_aa);
        chk("BA", BA, e_ba);
      end
      if (m_busy && m_wb && k == m_wr_cyc) begin
        chk("DA", DA, m_dest);
        chk("Data_in", Data_in, p_res);
      end else if (!m_busy && !rst) begin
        chk("DA_idle", DA, 0);
        chk("Data_in_idle", Data_in, 0);
      end
      if (e_wr) mrf[m_dest] = p_res;
      if (e_done) begin
        if (m_upd) begin s_res = p_res; s_c = p_c; s_z = p_z; s_ill = 0; end
        else s_ill = p_ill;
        m_busy = 0;
      end
      if (!m_busy) begin
        chk("result", result, s_res);
        chk("carry", carry, s_c);
        chk("zero", zero, s_z);
        chk("illegal", illegal, s_ill);
      end
      // effect of the coming edge
      if (rst) begin
        m_busy = 0; s_res = 0; s_c = 0; s_z = 0; s_ill = 0;
      end else if (instr_valid && e_rdy) begin
        model_accept(instr, k + 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] enc(input logic [3:0] o, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return {o, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] v);
    return {4'h7, d, 1'b0, v};
  endfunction

  // Returns the accepting edge number; leaves the bench in the cycle after it.
  task automatic issue(input logic [15:0] ins, output int acc);
    bit got;
    got = 0; acc = -1;
    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (instr_ready) begin got = 1; acc = cyc + 1; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit got;
    got = 0; dc = -1;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (done) begin got = 1; dc = cyc; end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [15:0] ins, input int e_res,
                        input int e_c, input int e_z, input int e_ill, input int e_lat);
    int acc, dc;
    issue(ins, acc);
    wait_done(dc);
    chk({nm, "_latency"}, dc - acc, e_lat);
    chk({nm, "_result"}, result, e_res);
    chk({nm, "_carry"}, carry, e_c);
    chk({nm, "_zero"}, zero, e_z);
    chk({nm, "_illegal"}, illegal, e_ill);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequences ----------------
  initial begin
    int acc;
    bit saw;
    logic [15:0] ops [3];
    int er [3];
    int ec [3];
    int acc_c [3];
    int idx, dcnt;
    bit sw;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_WR", WR, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);
    chk("rst_result", result, 0);

    // LDI / ADD with no carry; ALU done three cycles after acceptance
    run_op("ldi_r1",  ldi(1, 8'h7F), 8'h7F, 0, 0, 0, 1);
    run_op("ldi_r2",  ldi(2, 8'h01), 8'h01, 0, 0, 0, 1);
    run_op("add_r3",  enc(4'h1, 3, 1, 2), 8'h80, 0, 0, 0, 3);
    chk("rf_r3", rf[3], 8'h80);

    // carry out and borrow
    run_op("ldi_ff",  ldi(1, 8'hFF), 8'hFF, 0, 0, 0, 1);
    run_op("add_r4",  enc(4'h1, 4, 1, 2), 8'h00, 1, 1, 0, 3);
    run_op("sub_r5",  enc(4'h2, 5, 2, 1), 8'h02, 1, 0, 0, 3);

    // R0 operand is zero even though the read data holds 0x55
    run_op("ldi_r7",  ldi(7, 8'h55), 8'h55, 0, 0, 0, 1);
    run_op("mov_r5",  enc(4'h6, 5, 7, 0), 8'h55, 0, 0, 0, 3);
    run_op("ldi_r1b", ldi(1, 8'h10), 8'h10, 0, 0, 0, 1);
    chk("data_a_hold", Data_A, 8'h55);
    run_op("add_r6",  enc(4'h1, 6, 0, 1), 8'h10, 0, 0, 0, 3);

    // write to R0 suppressed, illegal opcode, NOP clears illegal
    run_op("mov_r0",  enc(4'h6, 0, 1, 0), 8'h10, 0, 0, 0, 3);
    chk("rf_r0", rf[0], 0);
    run_op("illegal", enc(4'hC, 3, 1, 2), 8'h10, 0, 0, 1, 0);
    chk("rf_r3_illegal", rf[3], 8'h80);
    run_op("nop",     enc(4'h0, 0, 0, 0), 8'h10, 0, 0, 0, 0);

    // reset during WB of ADD R3
    run_op("ldi_r1c", ldi(1, 8'h01), 8'h01, 0, 0, 0, 1);
    run_op("ldi_r2c", ldi(2, 8'h02), 8'h02, 0, 0, 0, 1);
    issue(enc(4'h1, 3, 1, 2), acc);      // now in RD
    @(posedge clk); #1;                  // CAP
    @(posedge clk); #1; rst = 1'b1;      // WB
    @(negedge clk);
    chk("wr_in_rst_wb", WR, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_post_abort", instr_ready, 1);
    saw = done;
    repeat (4) begin @(negedge clk); saw = saw | done; end
    chk("no_done_abort", saw, 0);
    chk("r3_unchanged", rf[3], 8'h80);
    chk("abort_result", result, 0);

    // back-to-back with instr_valid held high
    ops[0] = enc(4'h1, 3, 1, 2); er[0] = 8'h03; ec[0] = 0;
    ops[1] = enc(4'h2, 4, 1, 2); er[1] = 8'hFF; ec[1] = 1;
    ops[2] = enc(4'h8, 5, 3, 0); er[2] = 8'hFC; ec[2] = 0;
    idx = 0; dcnt = 0; sw = 0;
    acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
    @(posedge clk); #1;
    instr = ops[0]; instr_valid = 1'b1;
    for (int n = 0; n < 40 && dcnt < 3; n++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_result", result, er[dcnt]);
        chk("b2b_carry", carry, ec[dcnt]);
        dcnt++;
      end
      if (instr_ready && idx < 3) begin
        acc_c[idx] = cyc + 1; idx++; sw = 1;
      end
      @(posedge clk); #1;
      if (sw) begin
        if (idx < 3) instr = ops[idx];
        else instr_valid = 1'b0;
        sw = 0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_done_count", dcnt, 3);
    chk("b2b_spacing_01", acc_c[1] - acc_c[0], 5);
    chk("b2b_spacing_12", acc_c[2] - acc_c[1], 5);

    // remaining logic ops and a zero result from SUB
    run_op("or_r6",   enc(4'h4, 6, 4, 5), 8'hFF, 0, 0, 0, 3);
    run_op("and_r7",  enc(4'h3, 7, 4, 5), 8'hFC, 0, 0, 0, 3);
    run_op("xor_r6",  enc(4'h5, 6, 4, 5), 8'h03, 0, 0, 0, 3);
    run_op("sub_eq",  enc(4'h2, 7, 4, 4), 8'h00, 0, 1, 0, 3);
    chk("rf_r6", rf[6], 8'h03);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
